jtag_tap_oversampled: RTL and testbench

// - IEEE 1149.1 TAP controller run entirely in the system clock domain. TCK/TMS/TDI/TRSTn are oversampled on clk.
// - Sits directly downstream of the user-pin JTAG mapping.
// - Replaces the free-running TCK-clocked generated TAP where a single-clock design is required.
// - Provides IDCODE, BYPASS and one USER data register: capture from user inputs, update to user outputs.

---
 rtl/jtag_tap_oversampled_pkg.sv | 50 +++++
 rtl/jtag_tap_oversampled_if.sv | 30 +++
 rtl/jtag_tap_oversampled_pin_sync.sv | 39 +++
 rtl/jtag_tap_oversampled.sv | 160 ++++++++++++++++
 tb/tb_jtag_tap_oversampled.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_tap_oversampled_pkg.sv
// Shared types and constants for the oversampled JTAG TAP.
// Holds the state encoding, the opcodes and the TAP transition function.
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PAU_DR = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PAU_IR = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_t;

   localparam logic [2:0] OP_IDCODE = 3'b001;
   localparam logic [2:0] OP_USER   = 3'b010;
   localparam logic [2:0] OP_BYPASS = 3'b111;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      case (s)
         TLR:     tap_next = tms ? TLR    : RTI;
         RTI:     tap_next = tms ? SEL_DR : RTI;
         SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
         CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
         SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
         EX1_DR:  tap_next = tms ? UPD_DR : PAU_DR;
         PAU_DR:  tap_next = tms ? EX2_DR : PAU_DR;
         EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
         UPD_DR:  tap_next = tms ? SEL_DR : RTI;
         SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
         CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
         SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
         EX1_IR:  tap_next = tms ? UPD_IR : PAU_IR;
         PAU_IR:  tap_next = tms ? EX2_IR : PAU_IR;
         EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
         UPD_IR:  tap_next = tms ? SEL_DR : RTI;
         default: tap_next = TLR;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tap_oversampled_if.sv
// Pin-level JTAG plus USER data register bundle between the TAP and its environment.
interface jtag_tap_oversampled_if
   import jtag_tap_pkg::*;
#(
   parameter int IR_WIDTH = 3,
   parameter int DR_WIDTH = 8
) ();
   logic                tck;
   logic                tms;
   logic                tdi;
   logic                trst_n;
   logic                tdo;
   logic                tdo_oe;
   tap_state_t          tap_state;
   logic [IR_WIDTH-1:0] ir;
   logic                test_logic_reset;
   logic [DR_WIDTH-1:0] dr_in;
   logic [DR_WIDTH-1:0] dr_out;
   logic                dr_update;

   modport slave (
      input  tck, tms, tdi, trst_n, dr_in,
      output tdo, tdo_oe, tap_state, ir, test_logic_reset, dr_out, dr_update
   );

   modport master (
      output tck, tms, tdi, trst_n, dr_in,
      input  tdo, tdo_oe, tap_state, ir, test_logic_reset, dr_out, dr_update
   );
endinterface

// File: rtl/jtag_tap_oversampled_pin_sync.sv
// Synchronises the four raw JTAG pins into clk and derives one-clk TCK edge strobes.
module jtag_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tck_i,
   input  logic tms_i,
   input  logic tdi_i,
   input  logic trst_n_i,
   output logic tms_s_o,
   output logic tdi_s_o,
   output logic trst_n_s_o,
   output logic tck_rise_o,
   output logic tck_fall_o
);
   // Pin order {trst_n, tdi, tms, tck}; trst_n resets asserted so the TAP stays in TLR until it clears.
   localparam logic [3:0] PIN_RST = 4'b0010;

   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic                        tck_prev_q;

   // Synchroniser chain and previous synced TCK for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q     <= {SYNC_STAGES{PIN_RST}};
         tck_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], {trst_n_i, tdi_i, tms_i, tck_i}};
         tck_prev_q <= sync_q[SYNC_STAGES-1][0];
      end
   end

   assign tms_s_o    = sync_q[SYNC_STAGES-1][1];
   assign tdi_s_o    = sync_q[SYNC_STAGES-1][2];
   assign trst_n_s_o = sync_q[SYNC_STAGES-1][3];
   assign tck_rise_o = sync_q[SYNC_STAGES-1][0] & ~tck_prev_q;
   assign tck_fall_o = ~sync_q[SYNC_STAGES-1][0] & tck_prev_q;
endmodule

// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP clocked by clk; TCK edges arrive as strobes from the pin synchroniser.
// Provides IDCODE, BYPASS and one USER register with capture/update to user logic.
module jtag_tap_oversampled
   import jtag_tap_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          IR_WIDTH    = 3,
   parameter int          DR_WIDTH    = 8,
   parameter logic [31:0] IDCODE_VAL  = 32'h1000_0A6B
) (
   input logic                    clk_i,
   input logic                    rst_i,
   jtag_tap_oversampled_if.slave  bus
);
   logic tms_s, tdi_s, trst_n_s, tck_rise, tck_fall, adv_s;
   logic is_idcode_s, is_user_s, dr_lsb_s;

   tap_state_t          state_q, state_d;
   logic                tlr_q;
   logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
   logic [31:0]         id_sh_q, id_sh_d;
   logic [DR_WIDTH-1:0] dr_sh_q, dr_sh_d, dr_out_q, dr_out_d;
   logic                byp_q, byp_d, dr_upd_q, dr_upd_d;
   logic                tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;

   jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tck_i      (bus.tck),
      .tms_i      (bus.tms),
      .tdi_i      (bus.tdi),
      .trst_n_i   (bus.trst_n),
      .tms_s_o    (tms_s),
      .tdi_s_o    (tdi_s),
      .trst_n_s_o (trst_n_s),
      .tck_rise_o (tck_rise),
      .tck_fall_o (tck_fall)
   );

   // trst_n outranks a coincident TCK rise, so datapath actions are gated with it.
   assign adv_s       = tck_rise & trst_n_s;
   assign is_idcode_s = (ir_q == IR_WIDTH'(OP_IDCODE));
   assign is_user_s   = (ir_q == IR_WIDTH'(OP_USER));
   assign dr_lsb_s    = is_idcode_s ? id_sh_q[0] : (is_user_s ? dr_sh_q[0] : byp_q);

   // TAP state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= TLR;
         tlr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         tlr_q   <= (state_d == TLR);
      end
   end

   // TAP next-state decode.
   always_comb begin
      state_d = state_q;
      if (!trst_n_s) begin
         state_d = TLR;
      end else if (tck_rise) begin
         state_d = tap_next(state_q, tms_s);
      end else begin
         state_d = state_q;
      end
   end

   // Capture/shift/update and TDO next values.
   always_comb begin
      ir_d     = ir_q;
      ir_sh_d  = ir_sh_q;
      id_sh_d  = id_sh_q;
      dr_sh_d  = dr_sh_q;
      byp_d    = byp_q;
      dr_out_d = dr_out_q;
      dr_upd_d = 1'b0;
      tdo_d    = tdo_q;
      tdo_oe_d = tdo_oe_q;
      if (adv_s) begin
         case (state_q)
            CAP_IR: ir_sh_d = IR_WIDTH'(2'b01);
            SH_IR:  ir_sh_d = {tdi_s, ir_sh_q[IR_WIDTH-1:1]};
            UPD_IR: ir_d    = ir_sh_q;
            CAP_DR: begin
               if (is_idcode_s)    id_sh_d = IDCODE_VAL;
               else if (is_user_s) dr_sh_d = bus.dr_in;
               else                byp_d   = 1'b0;
            end
            SH_DR: begin
               if (is_idcode_s)    id_sh_d = {tdi_s, id_sh_q[31:1]};
               else if (is_user_s) dr_sh_d = {tdi_s, dr_sh_q[DR_WIDTH-1:1]};
               else                byp_d   = tdi_s;
            end
            UPD_DR: begin
               if (is_user_s) begin
                  dr_out_d = dr_sh_q;
                  dr_upd_d = 1'b1;
               end else begin
                  dr_upd_d = 1'b0;
               end
            end
            default: dr_upd_d = 1'b0;
         endcase
      end else begin
         dr_upd_d = 1'b0;
      end
      if (state_d == TLR) begin
         ir_d = IR_WIDTH'(OP_IDCODE);
      end else begin
         ir_d = ir_d;
      end
      if (tck_fall) begin
         if (state_q == SH_IR) begin
            tdo_d    = ir_sh_q[0];
            tdo_oe_d = 1'b1;
         end else if (state_q == SH_DR) begin
            tdo_d    = dr_lsb_s;
            tdo_oe_d = 1'b1;
         end else begin
            tdo_oe_d = 1'b0;
         end
      end else begin
         tdo_oe_d = tdo_oe_q;
      end
   end

   // Instruction, shift, hold and TDO registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ir_q     <= IR_WIDTH'(OP_IDCODE);
         ir_sh_q  <= '0;
         id_sh_q  <= 32'h0000_0000;
         dr_sh_q  <= '0;
         byp_q    <= 1'b0;
         dr_out_q <= '0;
         dr_upd_q <= 1'b0;
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         ir_sh_q  <= ir_sh_d;
         id_sh_q  <= id_sh_d;
         dr_sh_q  <= dr_sh_d;
         byp_q    <= byp_d;
         dr_out_q <= dr_out_d;
         dr_upd_q <= dr_upd_d;
         tdo_q    <= tdo_d;
         tdo_oe_q <= tdo_oe_d;
      end
   end

   assign bus.tdo              = tdo_q;
   assign bus.tdo_oe           = tdo_oe_q;
   assign bus.tap_state        = state_q;
   assign bus.ir               = ir_q;
   assign bus.test_logic_reset = tlr_q;
   assign bus.dr_out           = dr_out_q;
   assign bus.dr_update        = dr_upd_q;
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Randomised scoreboard bench for jtag_tap_oversampled against a shift-stream reference model.
`timescale 1ns/1ps
module tb_jtag_tap_oversampled;
   localparam int          IRW    = 3;
   localparam int          DRW    = 8;
   localparam logic [31:0] IDCODE = 32'h1000_0A6B;
   // Next-state tables, one nibble per state code: entry i is the successor of state i.
   localparam logic [63:0] NXT0 = 64'hCACC_BABA_62CE_3232;
   localparam logic [63:0] NXT1 = 64'hF977_89DD_417F_0155;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtag_tap_oversampled_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) bus ();

   jtag_tap_oversampled #(
      .SYNC_STAGES (2),
      .IR_WIDTH    (IRW),
      .DR_WIDTH    (DRW),
      .IDCODE_VAL  (IDCODE)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b1;
   bit          exp_q[$];
   logic [7:0]  upd_q[$];
   logic [3:0]  m_state = 4'hF;
   logic [2:0]  m_ir    = 3'b001;
   logic [7:0]  m_dr_out = 8'h00;
   logic [7:0]  saved;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic m_step(input bit tms);
      logic [63:0] tbl;
      tbl = tms ? NXT1 : NXT0;
      m_state = tbl[m_state*4 +: 4];
      if (m_state == 4'hF) m_ir = 3'b001;
   endtask

   task automatic tck_cycle(input bit tms, input bit tdi);
      @(negedge clk);
      bus.tms = tms;
      bus.tdi = tdi;
      repeat (2) @(negedge clk);
      bus.tck = 1'b1;
      m_step(tms);
      repeat (4) @(negedge clk);
      bus.tck = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic goto_rti();
      repeat (5) tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, "_state"}, bus.tap_state, m_state);
      check({tag, "_ir"}, bus.ir, m_ir);
      check({tag, "_oe_idle"}, bus.tdo_oe, 1'b0);
   endtask

   task automatic shift_ir(input logic [2:0] op);
      for (int k = 0; k < IRW; k++) exp_q.push_back(k == 0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < IRW; i++) tck_cycle(i == IRW - 1, op[i]);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      m_ir = op;
      check_idle("ir");
   endtask

   // Bits leave in the order: captured register contents, then the TDI stream.
   task automatic shift_dr(input logic [63:0] data, input int n);
      logic [127:0] stream;
      logic [63:0]  cap;
      int           len;
      stream = '0;
      if (m_ir == 3'b001)      begin len = 32; cap = {32'h0, IDCODE}; end
      else if (m_ir == 3'b010) begin len = DRW; cap = {56'h0, bus.dr_in}; end
      else                     begin len = 1;  cap = 64'h0; end
      for (int k = 0; k < len; k++) stream[k] = cap[k];
      for (int k = 0; k < n; k++)   stream[len + k] = data[k];
      for (int k = 0; k < n; k++)   exp_q.push_back(stream[k]);
      if (m_ir == 3'b010) begin
         m_dr_out = stream[n +: 8];
         upd_q.push_back(m_dr_out);
      end
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < n; i++) tck_cycle(i == n - 1, data[i]);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      check_idle("dr");
      check("dr_out_hold", bus.dr_out, m_dr_out);
   endtask

   task automatic enter_shdr_partial();
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b1);
      tck_cycle(1'b0, 1'b0);
   endtask

   // TDO monitor: every TCK rise with tdo_oe high presents one shifted-out bit.
   initial begin
      bit e;
      forever begin
         @(posedge bus.tck);
         if (mon_en && bus.tdo_oe) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tdo_unexpected: got %0b expected no output", bus.tdo);
            end else begin
               e = exp_q.pop_front();
               check("tdo_bit", bus.tdo, e);
            end
         end
      end
   end

   // Update monitor: each dr_update clock must match one expected update.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.dr_update) begin
            if (upd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dr_update_unexpected: got %0h expected no pulse", bus.dr_out);
            end else begin
               check("dr_update_val", bus.dr_out, upd_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish within 500us");
      $fatal(1, "timeout");
   end

   initial begin
      bus.tck = 1'b0; bus.tms = 1'b1; bus.tdi = 1'b0; bus.trst_n = 1'b1; bus.dr_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_state", bus.tap_state, 4'hF);
      check("rst_ir", bus.ir, 3'b001);
      check("rst_oe", bus.tdo_oe, 1'b0);
      check("rst_tdo", bus.tdo, 1'b0);
      check("rst_dr_out", bus.dr_out, 8'h00);
      check("rst_upd", bus.dr_update, 1'b0);
      check("rst_tlr", bus.test_logic_reset, 1'b1);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      repeat (5) tck_cycle(1'b1, 1'b0);
      @(negedge clk);
      check("tlr_hold_state", bus.tap_state, 4'hF);
      check("tlr_hold_flag", bus.test_logic_reset, 1'b1);

      tck_cycle(1'b0, 1'b0);
      check_idle("rti");
      check("rti_tlr_flag", bus.test_logic_reset, 1'b0);
      shift_dr(64'h0, 32);
      shift_ir(3'b010);
      bus.dr_in = 8'hA5;
      shift_dr(64'h3C, 8);
      shift_ir(3'b111);
      shift_dr(64'hC3, 8);
      shift_ir(3'b100);
      shift_dr(64'hC3, 8);

      for (int it = 0; it < 20; it++) begin
         int unsigned r;
         logic [2:0]  op;
         r = $urandom_range(0, 3);
         op = 3'($urandom_range(0, 7));
         if (r == 1) op = 3'b010;
         if (r == 2) op = 3'b001;
         bus.dr_in = 8'($urandom);
         if ($urandom_range(0, 4) == 0) goto_rti();
         shift_ir(op);
         shift_dr({32'($urandom), 32'($urandom)}, int'($urandom_range(1, 40)));
      end

      // trst_n during Shift-DR
      shift_ir(3'b010);
      saved = m_dr_out;
      mon_en = 1'b0;
      enter_shdr_partial();
      @(negedge clk);
      bus.trst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("trst_state", bus.tap_state, 4'hF);
      check("trst_ir", bus.ir, 3'b001);
      check("trst_tlr", bus.test_logic_reset, 1'b1);
      check("trst_dr_out", bus.dr_out, saved);
      m_state = 4'hF;
      m_ir = 3'b001;
      @(negedge clk);
      bus.trst_n = 1'b1;
      repeat (4) @(negedge clk);
      goto_rti();
      mon_en = 1'b1;

      // rst during Shift-DR
      shift_ir(3'b010);
      shift_dr(64'h5A, 8);
      mon_en = 1'b0;
      enter_shdr_partial();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_dr_out", bus.dr_out, 8'h00);
      check("rst_mid_state", bus.tap_state, 4'hF);
      check("rst_mid_ir", bus.ir, 3'b001);
      check("rst_mid_oe", bus.tdo_oe, 1'b0);
      m_state = 4'hF;
      m_ir = 3'b001;
      m_dr_out = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      goto_rti();
      mon_en = 1'b1;
      shift_dr(64'h0, 32);

      check("tdo_queue_empty", exp_q.size(), 0);
      check("upd_queue_empty", upd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
